safety_island_boot_ctrl: RTL

Boot sequencer for the safety island core.
- Samples the boot mode after reset and holds the core in reset with fetch disabled.
- Waits for the boot condition of that mode: a debugger START write for Jtag, or a preload-done strobe for Preloaded.
- Drives the boot address, releases core reset, then enables instruction fetch.
- Sits between the SoC boot-mode pins / preload logic and the core's reset, fetch-enable and boot-address inputs; its small register window sits in the peripheral region.

---
 rtl/safety_island_pkg.sv | 27 ++
 rtl/safety_island_boot_regs.sv | 65 ++++++
 rtl/safety_island_boot_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/safety_island_pkg.sv
// Shared types and register offsets for the safety island boot sequencer.
package safety_island_pkg;

  typedef enum logic [1:0] {
    Jtag      = 2'b00,
    Preloaded = 2'b01
  } bootmode_e;

  // Encodings are exposed in STATUS[2:0] and must stay stable.
  typedef enum logic [2:0] {
    StSample      = 3'd0,
    StWaitJtag    = 3'd1,
    StWaitPreload = 3'd2,
    StRelease     = 3'd3,
    StBoot        = 3'd4,
    StRunning     = 3'd5,
    StError       = 3'd6
  } boot_state_e;

  localparam logic [3:0] BootAddrOffset = 4'h0;
  localparam logic [3:0] StartOffset    = 4'h4;
  localparam logic [3:0] StatusOffset   = 4'h8;

  localparam logic [31:0] BaseAddr32 = 32'h0000_0000;
  localparam logic [31:0] MemOffset  = 32'h0000_0000;

endpackage

// File: rtl/safety_island_boot_regs.sv
// Register window of the boot sequencer: BOOT_ADDR, START and STATUS with a
// req/gnt handshake and a registered read response.
module safety_island_boot_regs
  import safety_island_pkg::*;
#(
  parameter logic [31:0] BootAddrDefault = BaseAddr32 + MemOffset
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cfg_req_i,
  input  logic        cfg_we_i,
  input  logic [3:0]  cfg_addr_i,
  input  logic [31:0] cfg_wdata_i,
  output logic        cfg_gnt_o,
  output logic        cfg_rvalid_o,
  output logic [31:0] cfg_rdata_o,
  input  logic        addr_wr_en_i,
  input  logic [31:0] status_i,
  output logic        start_pulse_o,
  output logic [31:0] boot_addr_o
);

  logic [31:0] boot_addr_q, boot_addr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q;
  logic        wr, rd;

  assign wr = cfg_req_i & cfg_we_i;
  assign rd = cfg_req_i & ~cfg_we_i;

  assign cfg_gnt_o     = cfg_req_i;
  assign start_pulse_o = wr && (cfg_addr_i == StartOffset) && cfg_wdata_i[0];

  always_comb begin
    boot_addr_d = boot_addr_q;
    if (wr && (cfg_addr_i == BootAddrOffset) && addr_wr_en_i) begin
      boot_addr_d = cfg_wdata_i;
    end
    rdata_d = '0;
    if (rd) begin
      case (cfg_addr_i)
        BootAddrOffset: rdata_d = boot_addr_q;
        StatusOffset:   rdata_d = status_i;
        default:        rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      boot_addr_q <= BootAddrDefault;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      boot_addr_q <= boot_addr_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= cfg_req_i;
    end
  end

  assign cfg_rvalid_o = rvalid_q;
  assign cfg_rdata_o  = rdata_q;
  assign boot_addr_o  = boot_addr_q;

endmodule

// File: rtl/safety_island_boot_ctrl.sv
// Boot sequencer for the safety island core: samples the boot mode, waits for
// the boot trigger, then releases reset and enables fetch. Optional preload
// timeout enabled by SAFETY_ISLAND_BOOT_TIMEOUT_EN.
module safety_island_boot_ctrl
  import safety_island_pkg::*;
#(
  parameter logic [31:0] BootAddrDefault = BaseAddr32 + MemOffset,
  parameter int unsigned ResetHoldCycles = 4,
  parameter int unsigned TimeoutCycles   = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  bootmode_i,
  input  logic        preload_done_i,
  input  logic        cfg_req_i,
  input  logic        cfg_we_i,
  input  logic [3:0]  cfg_addr_i,
  input  logic [31:0] cfg_wdata_i,
  output logic        cfg_gnt_o,
  output logic        cfg_rvalid_o,
  output logic [31:0] cfg_rdata_o,
  output logic [31:0] boot_addr_o,
  output logic        core_rst_o,
  output logic        fetch_en_o,
  output logic        error_o
);

  localparam int unsigned HoldW = $clog2(ResetHoldCycles + 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(ResetHoldCycles - 1);

  boot_state_e      state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic             start_pulse;
  logic             addr_wr_en;
  logic [31:0]      status;

`ifdef SAFETY_ISLAND_BOOT_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
`else
  logic unused_tmo;
  assign unused_tmo = (TimeoutCycles == 0);
`endif

  assign addr_wr_en = (state_q == StSample) || (state_q == StWaitJtag) ||
                      (state_q == StWaitPreload);
  assign status     = {26'b0, mode_q, (state_q == StError), state_q};

  safety_island_boot_regs #(
    .BootAddrDefault(BootAddrDefault)
  ) u_regs (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cfg_req_i    (cfg_req_i),
    .cfg_we_i     (cfg_we_i),
    .cfg_addr_i   (cfg_addr_i),
    .cfg_wdata_i  (cfg_wdata_i),
    .cfg_gnt_o    (cfg_gnt_o),
    .cfg_rvalid_o (cfg_rvalid_o),
    .cfg_rdata_o  (cfg_rdata_o),
    .addr_wr_en_i (addr_wr_en),
    .status_i     (status),
    .start_pulse_o(start_pulse),
    .boot_addr_o  (boot_addr_o)
  );

  // Counters clear whenever their state is not active, so each entry starts at 0.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    hold_cnt_d = '0;
`ifdef SAFETY_ISLAND_BOOT_TIMEOUT_EN
    tmo_cnt_d  = '0;
`endif
    unique case (state_q)
      StSample: begin
        mode_d = bootmode_i;
        if (bootmode_i == Jtag)           state_d = StWaitJtag;
        else if (bootmode_i == Preloaded) state_d = StWaitPreload;
        else                              state_d = StError;
      end
      StWaitJtag: begin
        if (start_pulse) state_d = StRelease;
      end
      StWaitPreload: begin
`ifdef SAFETY_ISLAND_BOOT_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        // A strobe on the final counted cycle still boots.
        if (preload_done_i)             state_d = StRelease;
        else if (tmo_cnt_q == TmoLast)  state_d = StError;
`else
        if (preload_done_i) state_d = StRelease;
`endif
      end
      StRelease: begin
        hold_cnt_d = hold_cnt_q + 1'b1;
        if (hold_cnt_q == HoldLast) state_d = StBoot;
      end
      StBoot:    state_d = StRunning;
      StRunning: state_d = StRunning;
      StError:   state_d = StError;
      default:   state_d = StError;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StSample;
      mode_q     <= 2'b00;
      hold_cnt_q <= '0;
`ifdef SAFETY_ISLAND_BOOT_TIMEOUT_EN
      tmo_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      hold_cnt_q <= hold_cnt_d;
`ifdef SAFETY_ISLAND_BOOT_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
`endif
    end
  end

  assign core_rst_o = !((state_q == StBoot) || (state_q == StRunning));
  assign fetch_en_o = (state_q == StRunning);
  assign error_o    = (state_q == StError);

endmodule
